// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enabled simple dual-port RAM.
package ram_pkg;

  typedef enum logic {CLEAR, READY} state_e;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  // Index width needed to address a given number of words (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_sdp_core.sv
// Storage array: one byte-enabled write port, one registered read port, no reset.
module ram_sdp_core
  import ram_pkg::*;
#(
  parameter int unsigned k = 32,
  parameter int unsigned l = 64
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [k/8-1:0]            i_be,
  input  logic [idx_width(l)-1:0]   i_wadr,
  input  logic [k-1:0]              i_wdata,
  input  logic                      i_re,
  input  logic [idx_width(l)-1:0]   i_radr,
  output logic [k-1:0]              o_rdata
);

  logic [k-1:0] r_mem [l];
  logic [k-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < int'(k / 8); i++) begin
        if (i_be[i]) r_mem[i_wadr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_radr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_sdp_be.sv
// Byte-enabled SDP RAM with power-up zero sweep, range checks, read-during-write
// merge and a 1- or 2-cycle read pipeline.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int unsigned k        = 32,
  parameter int unsigned l        = 64,
  parameter int unsigned m        = 7,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [k/8-1:0] be,
  input  logic [m-1:0]   write_adr,
  input  logic [k-1:0]   data_in,
  input  logic           re,
  input  logic [m-1:0]   read_adr,
  output logic [k-1:0]   data_out,
  output logic           rd_valid,
  output logic           busy
);

  localparam int unsigned NB = k / 8;
  localparam int unsigned AW = idx_width(l);
  localparam logic [m:0] AdrLim = (m + 1)'(l);
  localparam logic [AW-1:0] LastIdx = AW'(l - 1);

  state_e r_state, w_state_nxt;
  logic [AW-1:0] r_clr_ptr, w_clr_ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    unique case (r_state)
      CLEAR: begin
        if (r_clr_ptr == LastIdx) begin
          w_state_nxt   = READY;
          w_clr_ptr_nxt = '0;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        end
      end
      READY: ;
    endcase
  end

  assign busy = (r_state == CLEAR);

  logic w_wr_ok, w_rd_acc, w_rd_in, w_rdw_hit;
  logic [k-1:0] w_core_rdata;

  assign w_wr_ok   = we & ~busy & ~rst & ({1'b0, write_adr} < AdrLim);
  assign w_rd_acc  = re & ~busy & ~rst;
  assign w_rd_in   = ({1'b0, read_adr} < AdrLim);
  assign w_rdw_hit = w_wr_ok & w_rd_acc & (read_adr == write_adr);

  // The sweep owns the write port while busy; user requests are dropped.
  ram_sdp_core #(
    .k (k),
    .l (l)
  ) u_core (
    .clk     (clk),
    .i_we    (busy | w_wr_ok),
    .i_be    (busy ? {NB{1'b1}} : be),
    .i_wadr  (busy ? r_clr_ptr : write_adr[AW-1:0]),
    .i_wdata (busy ? '0 : data_in),
    .i_re    (w_rd_acc & w_rd_in),
    .i_radr  (read_adr[AW-1:0]),
    .o_rdata (w_core_rdata)
  );

  logic           r_s1_valid, r_s1_zero;
  logic [NB-1:0]  r_s1_mask;
  logic [k-1:0]   r_s1_byp;
  logic [k-1:0]   w_s1_data;

  // Side-band for the array read: out-of-range zeroing and write-lane bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_zero  <= 1'b1;
      r_s1_mask  <= '0;
      r_s1_byp   <= '0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_zero <= ~w_rd_in;
        r_s1_mask <= (RDW_MODE == RDW_NEW && w_rdw_hit) ? be : '0;
        r_s1_byp  <= data_in;
      end
    end
  end

  always_comb begin
    w_s1_data = '0;
    for (int i = 0; i < int'(NB); i++) begin
      w_s1_data[8*i +: 8] = r_s1_mask[i] ? r_s1_byp[8*i +: 8] : w_core_rdata[8*i +: 8];
    end
    if (r_s1_zero) w_s1_data = '0;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic         r_s2_valid;
    logic [k-1:0] r_s2_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_valid <= 1'b0;
        r_s2_data  <= '0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_s2_data <= w_s1_data;
      end
    end

    assign data_out = r_s2_data;
    assign rd_valid = r_s2_valid;
  end else begin : g_lat1
    assign data_out = w_s1_data;
    assign rd_valid = r_s1_valid;
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench: three instances (default, RD_LAT=2, RDW_MODE=1) share one stimulus stream.
module tb_ram_sdp_be;

  logic        clk;
  logic        rst;
  logic        we;
  logic [3:0]  be;
  logic [6:0]  write_adr;
  logic [31:0] data_in;
  logic        re;
  logic [6:0]  read_adr;

  logic [31:0] do0, do2, don;
  logic        rv0, rv2, rvn;
  logic        bz0, bz2, bzn;

  int errors = 0;
  int checks = 0;
  int cnt;
  int vseen;

  ram_sdp_be dut0 (
    .clk(clk), .rst(rst), .we(we), .be(be), .write_adr(write_adr), .data_in(data_in),
    .re(re), .read_adr(read_adr), .data_out(do0), .rd_valid(rv0), .busy(bz0)
  );

  ram_sdp_be #(.RD_LAT(2)) dut_lat2 (
    .clk(clk), .rst(rst), .we(we), .be(be), .write_adr(write_adr), .data_in(data_in),
    .re(re), .read_adr(read_adr), .data_out(do2), .rd_valid(rv2), .busy(bz2)
  );

  ram_sdp_be #(.RDW_MODE(1)) dut_new (
    .clk(clk), .rst(rst), .we(we), .be(be), .write_adr(write_adr), .data_in(data_in),
    .re(re), .read_adr(read_adr), .data_out(don), .rd_valid(rvn), .busy(bzn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1;
    write_adr = a;
    data_in = d;
    be = b;
    step();
    we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; be = 4'h0;
    write_adr = '0; data_in = '0; read_adr = '0;
    step();
    chk("rst_data", do0, 32'h0);
    chk1("rst_valid", rv0, 1'b0);
    chk1("rst_busy", bz0, 1'b1);
    chk("rst_data_lat2", do2, 32'h0);
    chk1("rst_valid_lat2", rv2, 1'b0);
    chk1("rst_busy_new", bzn, 1'b1);

    // Requests held during the sweep must be ignored.
    rst = 1'b0;
    we = 1'b1; be = 4'hF; write_adr = 7'd3; data_in = 32'hDEADBEEF;
    re = 1'b1; read_adr = 7'd3;
    cnt = 0; vseen = 0;
    while (bz0 && cnt < 200) begin
      cnt++;
      step();
      if (rv0 || rv2 || rvn) vseen++;
    end
    we = 1'b0; re = 1'b0;
    chk("busy_cycles", cnt, 32'd64);
    chk("sweep_rd_valid", vseen, 32'd0);
    chk1("busy_done_lat2", bz2, 1'b0);
    chk1("busy_done_new", bzn, 1'b0);

    for (int a = 0; a < 64; a++) begin
      re = 1'b1; read_adr = 7'(a);
      step();
      chk("clear_read", do0, 32'h0);
      chk1("clear_valid", rv0, 1'b1);
    end
    re = 1'b0;

    wr(7'd5, 32'hAABBCCDD, 4'hF);
    wr(7'd5, 32'h11223344, 4'h5);
    re = 1'b1; read_adr = 7'd5;
    step();
    re = 1'b0;
    chk("be_merge", do0, 32'hAA22CC44);
    chk1("be_merge_valid", rv0, 1'b1);
    chk("be_merge_new", don, 32'hAA22CC44);
    chk1("lat2_not_yet", rv2, 1'b0);
    step();
    chk("be_merge_lat2", do2, 32'hAA22CC44);
    chk1("be_merge_lat2_valid", rv2, 1'b1);
    chk1("hold_valid", rv0, 1'b0);
    chk("hold_data", do0, 32'hAA22CC44);

    wr(7'd1, 32'h11110001, 4'hF);
    wr(7'd2, 32'h22220002, 4'hF);
    wr(7'd3, 32'h33330003, 4'hF);
    re = 1'b1; read_adr = 7'd1;
    step();
    chk1("b2b_first_edge", rv2, 1'b0);
    chk("b2b_lat1", do0, 32'h11110001);
    read_adr = 7'd2;
    step();
    chk1("b2b_v1", rv2, 1'b1);
    chk("b2b_d1", do2, 32'h11110001);
    read_adr = 7'd3;
    step();
    chk1("b2b_v2", rv2, 1'b1);
    chk("b2b_d2", do2, 32'h22220002);
    re = 1'b0;
    step();
    chk1("b2b_v3", rv2, 1'b1);
    chk("b2b_d3", do2, 32'h33330003);
    step();
    chk1("b2b_end", rv2, 1'b0);
    chk("b2b_hold", do2, 32'h33330003);

    wr(7'd9, 32'h0, 4'hF);
    we = 1'b1; be = 4'h3; write_adr = 7'd9; data_in = 32'hFFFFFFFF;
    re = 1'b1; read_adr = 7'd9;
    step();
    we = 1'b0;
    chk("rdw_old", do0, 32'h0);
    chk("rdw_new", don, 32'h0000FFFF);
    chk1("rdw_new_valid", rvn, 1'b1);
    step();
    re = 1'b0;
    chk("raw_next_old", do0, 32'h0000FFFF);
    chk("raw_next_new", don, 32'h0000FFFF);
    chk("rdw_old_lat2", do2, 32'h0);
    chk1("rdw_old_lat2_valid", rv2, 1'b1);
    step();
    chk("raw_next_lat2", do2, 32'h0000FFFF);

    wr(7'd100, 32'h12345678, 4'hF);
    wr(7'd5, 32'hFFFFFFFF, 4'h0);
    re = 1'b1; read_adr = 7'd100;
    step();
    chk("oob_read", do0, 32'h0);
    chk1("oob_valid", rv0, 1'b1);
    chk("oob_read_new", don, 32'h0);
    read_adr = 7'd5;
    step();
    chk("be_zero_nochange", do0, 32'hAA22CC44);
    read_adr = 7'd36;
    step();
    chk("oob_no_alias", do0, 32'h0);
    re = 1'b0;
    step();
    chk1("idle_valid", rv0, 1'b0);

    // Reset with a read in flight, then again partway through the sweep.
    re = 1'b1; read_adr = 7'd5;
    step();
    rst = 1'b1; re = 1'b0;
    step();
    chk1("midread_rst_valid_lat2", rv2, 1'b0);
    chk("midread_rst_data_lat2", do2, 32'h0);
    chk("midread_rst_data", do0, 32'h0);
    chk1("midread_rst_busy", bz0, 1'b1);
    rst = 1'b0;
    re = 1'b1; read_adr = 7'd5;
    vseen = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (rv0 || rv2 || rvn) vseen++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    while (bz0 && cnt < 200) begin
      cnt++;
      step();
      if (rv0 || rv2 || rvn) vseen++;
    end
    re = 1'b0;
    chk("resweep_busy_cycles", cnt, 32'd64);
    chk("resweep_rd_valid", vseen, 32'd0);
    re = 1'b1; read_adr = 7'd5;
    step();
    re = 1'b0;
    chk("resweep_cleared", do0, 32'h0);
    chk1("resweep_valid", rv0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
